pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Merges stall requests from the decode and execute stages into one stall vector.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_ctrl_mc_watchdog.sv | 28 ++
 rtl/pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned StallW = 6;

    // Stall vector bits: [0]pc [1]if/id [2]id/ex [3]ex/mem [4]mem/wb [5]wb
    localparam logic [StallW-1:0] StallNone = 6'b000000;
    localparam logic [StallW-1:0] StallId   = 6'b000111;
    localparam logic [StallW-1:0] StallEx   = 6'b001111;

    typedef enum logic [1:0] {
        CtrlIdle   = 2'd0,
        CtrlMcBusy = 2'd1,
        CtrlFlush  = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_mc_watchdog.sv
// Watchdog for the multi-cycle unit: 8-bit up-counter with synchronous clear
// and enable; expired is high while the count equals Timeout-1.
module pipe_ctrl_mc_watchdog #(
    parameter int unsigned Timeout = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] cnt_q;

    // Count cycles of an outstanding multi-cycle op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else if (clear) begin
            cnt_q <= 8'd0;
        end else if (enable) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign expired = (cnt_q == 8'(Timeout - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, runs the multi-cycle unit
// handshake with a watchdog, and sequences flushes with a redirect PC.
// Optional: define PIPE_PERF_CNT_EN to add stall-cycle and flush counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MC_TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id_i,
    input  logic              mc_req_i,
    input  logic              mc_done_i,
    input  logic              flush_req_i,
    input  logic [31:0]       flush_pc_i,
    output logic [StallW-1:0] stall_o,
    output logic              mc_start_o,
    output logic              mc_cancel_o,
    output logic              mc_err_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles_o,
    output logic [15:0]       flush_cnt_o
`endif
);

    ctrl_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic        wd_run;
    logic        wd_expired;

    pipe_ctrl_mc_watchdog #(
        .Timeout (MC_TIMEOUT)
    ) u_mc_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!wd_run),
        .enable  (wd_run),
        .expired (wd_expired)
    );

    // Next-state and same-cycle handshake outputs; flush beats multi-cycle beats load-use.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fcnt_d      = fcnt_q;
        stall_o     = StallNone;
        mc_start_o  = 1'b0;
        mc_cancel_o = 1'b0;
        mc_err_o    = 1'b0;
        wd_run      = 1'b0;
        unique case (state_q)
            CtrlIdle: begin
                if (flush_req_i) begin
                    pc_d    = flush_pc_i;
                    fcnt_d  = 4'd0;
                    state_d = CtrlFlush;
                end else if (mc_req_i) begin
                    mc_start_o = 1'b1;
                    stall_o    = StallEx;
                    wd_run     = 1'b1;  // start cycle is watchdog cycle 0
                    state_d    = CtrlMcBusy;
                end else if (stallreq_id_i) begin
                    stall_o = StallId;
                end
            end
            CtrlMcBusy: begin
                if (flush_req_i) begin
                    mc_cancel_o = 1'b1;
                    pc_d        = flush_pc_i;
                    fcnt_d      = 4'd0;
                    state_d     = CtrlFlush;
                end else if (mc_done_i) begin
                    state_d = CtrlIdle;
                end else if (wd_expired) begin
                    mc_err_o    = 1'b1;
                    mc_cancel_o = 1'b1;
                    state_d     = CtrlIdle;
                end else begin
                    stall_o = StallEx;
                    wd_run  = 1'b1;
                end
            end
            CtrlFlush: begin
                if (flush_req_i) begin
                    pc_d   = flush_pc_i;
                    fcnt_d = 4'd0;
                end else if (fcnt_q == 4'(FLUSH_CYCLES - 1)) begin
                    state_d = CtrlIdle;
                end else begin
                    fcnt_d = fcnt_q + 4'd1;
                end
            end
            default: state_d = CtrlIdle;
        endcase
    end

    // State, redirect PC and flush-length counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CtrlIdle;
            pc_q    <= 32'd0;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign flush_o  = (state_q == CtrlFlush);
    assign new_pc_o = pc_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_cnt_q;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= 32'd0;
            flush_cnt_q    <= 16'd0;
        end else begin
            if ((stall_o != StallNone) && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if ((state_q != CtrlFlush) && (state_d == CtrlFlush) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_cnt_o    = flush_cnt_q;
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (default parameters, and FLUSH_CYCLES=3 /
// MC_TIMEOUT=4) share the same stimulus and are checked every cycle against a
// behavioural model, plus literal expectations at key points.
module tb_pipe_ctrl;

    typedef struct {
        int          mode;  // 0 idle, 1 waiting on multi-cycle unit, 2 flushing
        int          left;  // flush cycles still to show, including this one
        int          age;   // cycles since the start pulse
        logic [31:0] pc;
    } mdl_t;

    typedef struct packed {
        logic [5:0]  stall;
        logic        start;
        logic        cancel;
        logic        err;
        logic        flush;
        logic [31:0] pc;
    } outs_t;

    localparam int FC0 = 1;
    localparam int TO0 = 64;
    localparam int FC1 = 3;
    localparam int TO1 = 4;

    logic        clk;
    logic        rst;
    logic        sreq, mreq, done, freq;
    logic [31:0] fpc;

    logic [5:0]  stall_w  [2];
    logic        start_w  [2];
    logic        cancel_w [2];
    logic        err_w    [2];
    logic        flush_w  [2];
    logic [31:0] pc_w     [2];

    mdl_t m [2];
    int   n_checks = 0;
    int   n_errors = 0;

    pipe_ctrl u_dut_d (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id_i (sreq),
        .mc_req_i      (mreq),
        .mc_done_i     (done),
        .flush_req_i   (freq),
        .flush_pc_i    (fpc),
        .stall_o       (stall_w[0]),
        .mc_start_o    (start_w[0]),
        .mc_cancel_o   (cancel_w[0]),
        .mc_err_o      (err_w[0]),
        .flush_o       (flush_w[0]),
        .new_pc_o      (pc_w[0])
    );

    pipe_ctrl #(
        .FLUSH_CYCLES (FC1),
        .MC_TIMEOUT   (TO1)
    ) u_dut_t (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id_i (sreq),
        .mc_req_i      (mreq),
        .mc_done_i     (done),
        .flush_req_i   (freq),
        .flush_pc_i    (fpc),
        .stall_o       (stall_w[1]),
        .mc_start_o    (start_w[1]),
        .mc_cancel_o   (cancel_w[1]),
        .mc_err_o      (err_w[1]),
        .flush_o       (flush_w[1]),
        .new_pc_o      (pc_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int fc_of(input int i);
        return (i == 0) ? FC0 : FC1;
    endfunction

    function automatic int to_of(input int i);
        return (i == 0) ? TO0 : TO1;
    endfunction

    function automatic outs_t out_of(input mdl_t s, input int to);
        outs_t o;
        o = '0;
        o.pc = s.pc;
        if (s.mode == 0) begin
            if (!freq && mreq) begin
                o.start = 1'b1;
                o.stall = 6'b001111;
            end else if (!freq && sreq) begin
                o.stall = 6'b000111;
            end
        end else if (s.mode == 1) begin
            if (freq) begin
                o.cancel = 1'b1;
            end else if (!done && s.age == to - 1) begin
                o.err    = 1'b1;
                o.cancel = 1'b1;
            end else if (!done) begin
                o.stall = 6'b001111;
            end
        end else begin
            o.flush = 1'b1;
        end
        return o;
    endfunction

    function automatic mdl_t next_of(input mdl_t s, input int fc, input int to);
        mdl_t n;
        n = s;
        if (freq) begin
            n.mode = 2;
            n.left = fc;
            n.pc   = fpc;
        end else if (s.mode == 0) begin
            if (mreq) begin
                n.mode = 1;
                n.age  = 1;
            end
        end else if (s.mode == 1) begin
            if (done || s.age == to - 1) n.mode = 0;
            else n.age = s.age + 1;
        end else begin
            n.left = s.left - 1;
            if (n.left == 0) n.mode = 0;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic compare(input int i);
        outs_t e;
        e = out_of(m[i], to_of(i));
        chk($sformatf("model.stall[%0d]", i), 32'(stall_w[i]), 32'(e.stall));
        chk($sformatf("model.start[%0d]", i), 32'(start_w[i]), 32'(e.start));
        chk($sformatf("model.cancel[%0d]", i), 32'(cancel_w[i]), 32'(e.cancel));
        chk($sformatf("model.err[%0d]", i), 32'(err_w[i]), 32'(e.err));
        chk($sformatf("model.flush[%0d]", i), 32'(flush_w[i]), 32'(e.flush));
        chk($sformatf("model.new_pc[%0d]", i), pc_w[i], e.pc);
    endtask

    // Model state follows the DUT clock and async reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) m[i] <= '{mode: 0, left: 0, age: 0, pc: 32'd0};
        end else begin
            for (int i = 0; i < 2; i++) m[i] <= next_of(m[i], fc_of(i), to_of(i));
        end
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        compare(0);
        compare(1);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sreq = 1'b0;
        mreq = 1'b0;
        done = 1'b0;
        freq = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        fpc = 32'd0;

        // Reset state
        mid();
        mid();
        chk("reset.stall", 32'(stall_w[0]), 32'h0);
        chk("reset.flush", 32'(flush_w[0]), 32'h0);
        chk("reset.new_pc", pc_w[0], 32'h0);
        nxt();
        rst = 1'b1;
        repeat (2) nxt();

        // Load-use stall for two cycles only
        sreq = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("id_stall", 32'(stall_w[0]), 32'h07);
            chk("id_no_start", 32'(start_w[0]), 32'h0);
            nxt();
        end
        sreq = 1'b0;
        mid();
        chk("id_release", 32'(stall_w[0]), 32'h00);

        // mc_done outside MC_BUSY is ignored
        nxt();
        done = 1'b1;
        mid();
        chk("stray_done", 32'(stall_w[0]), 32'h00);
        nxt();
        done = 1'b0;
        nxt();

        // Multi-cycle op: start at T0, done at T5
        mreq = 1'b1;
        mid();
        chk("mc_start_t0", 32'(start_w[0]), 32'h1);
        chk("mc_stall_t0", 32'(stall_w[0]), 32'h0f);
        for (int k = 1; k < 5; k++) begin
            nxt();
            mid();
            chk("mc_start_once", 32'(start_w[0]), 32'h0);
            chk("mc_stall_busy", 32'(stall_w[0]), 32'h0f);
        end
        nxt();
        done = 1'b1;
        mid();
        chk("mc_done_release", 32'(stall_w[0]), 32'h00);
        nxt();
        idle_inputs();
        repeat (2) nxt();

        // Flush beats done while busy
        mreq = 1'b1;
        nxt();
        nxt();
        freq = 1'b1;
        done = 1'b1;
        fpc  = 32'h0000_0180;
        mid();
        chk("flush_cancel", 32'(cancel_w[0]), 32'h1);
        chk("flush_cancel_stall", 32'(stall_w[0]), 32'h00);
        nxt();
        idle_inputs();
        mid();
        chk("flush_o_after_cancel", 32'(flush_w[0]), 32'h1);
        chk("flush_pc_after_cancel", pc_w[0], 32'h0000_0180);
        chk("flush_stall", 32'(stall_w[0]), 32'h00);
        nxt();
        mid();
        chk("flush_one_cycle", 32'(flush_w[0]), 32'h0);
        repeat (4) nxt();

        // Watchdog on the MC_TIMEOUT=4 instance; request still held restarts
        mreq = 1'b1;
        mid();
        chk("wd_start", 32'(start_w[1]), 32'h1);
        for (int k = 1; k < 3; k++) begin
            nxt();
            mid();
            chk("wd_quiet", 32'(err_w[1]), 32'h0);
        end
        nxt();
        mid();
        chk("wd_err", 32'(err_w[1]), 32'h1);
        chk("wd_cancel", 32'(cancel_w[1]), 32'h1);
        chk("wd_stall_release", 32'(stall_w[1]), 32'h00);
        nxt();
        mid();
        chk("wd_restart", 32'(start_w[1]), 32'h1);
        nxt();
        mreq = 1'b0;
        done = 1'b1;
        nxt();
        idle_inputs();
        repeat (2) nxt();

        // Back-to-back flush on the FLUSH_CYCLES=3 instance
        freq = 1'b1;
        fpc  = 32'h0000_0100;
        mid();
        chk("fl_t0", 32'(flush_w[1]), 32'h0);
        nxt();
        freq = 1'b0;
        mid();
        chk("fl_t1", 32'(flush_w[1]), 32'h1);
        chk("fl_t1_pc", pc_w[1], 32'h0000_0100);
        nxt();
        freq = 1'b1;
        fpc  = 32'h0000_0200;
        mid();
        chk("fl_t2", 32'(flush_w[1]), 32'h1);
        chk("fl_t2_pc", pc_w[1], 32'h0000_0100);
        for (int k = 3; k < 6; k++) begin
            nxt();
            freq = 1'b0;
            mreq = 1'b1;  // ignored while flushing
            mid();
            chk("fl_hold", 32'(flush_w[1]), 32'h1);
            chk("fl_hold_pc", pc_w[1], 32'h0000_0200);
            chk("fl_ignore_mc", 32'(start_w[1]), 32'h0);
        end
        nxt();
        mreq = 1'b0;
        mid();
        chk("fl_end", 32'(flush_w[1]), 32'h0);
        repeat (4) nxt();

        // Priority in IDLE: flush over mc over id
        freq = 1'b1;
        mreq = 1'b1;
        sreq = 1'b1;
        fpc  = 32'h0000_0abc;
        mid();
        chk("prio_flush_start", 32'(start_w[0]), 32'h0);
        chk("prio_flush_stall", 32'(stall_w[0]), 32'h00);
        nxt();
        idle_inputs();
        repeat (4) nxt();
        mreq = 1'b1;
        sreq = 1'b1;
        mid();
        chk("prio_mc_stall", 32'(stall_w[0]), 32'h0f);
        nxt();
        mreq = 1'b0;
        sreq = 1'b0;
        done = 1'b1;
        nxt();
        idle_inputs();
        nxt();

        // Async reset while busy: no cancel pulse
        mreq = 1'b1;
        nxt();
        mreq = 1'b0;
        #2 rst = 1'b0;
        mid();
        chk("rst_busy_cancel", 32'(cancel_w[0]), 32'h0);
        chk("rst_busy_stall", 32'(stall_w[0]), 32'h00);
        nxt();
        rst = 1'b1;
        repeat (3) nxt();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
